// File: rtl/instr_pkg.sv
// Shared types for the writable program store: loader FSM states and machine word type.
package instr_pkg;

    localparam int unsigned INSTR_W = 9;

    typedef logic [INSTR_W-1:0] mach_word_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERR
    } ldr_state_t;

endpackage

// File: rtl/instr_ram.sv
// 2**D x 9 program RAM: one synchronous write port, one asynchronous read port for fetch.
module instr_ram
    import instr_pkg::*;
#(
    parameter int unsigned D = 10
) (
    input  logic         clk,
    input  logic         i_we,
    input  logic [D-1:0] i_waddr,
    input  mach_word_t   i_wdata,
    input  logic [D-1:0] i_raddr,
    output mach_word_t   o_rdata
);

    mach_word_t r_mem [2**D];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_loader.sv
// Streams a program into the fetch RAM, verifies a trailing XOR checksum, then releases the core.
module instr_loader
    import instr_pkg::*;
#(
    parameter int unsigned D = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [D:0]   load_len,
    input  logic         in_valid,
    input  mach_word_t   in_data,
    output logic         in_ready,
    input  logic [D-1:0] prog_ctr,
    output mach_word_t   mach_code,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);

    localparam logic [D:0] DEPTH = {1'b1, {D{1'b0}}};

    ldr_state_t   r_state;
    ldr_state_t   w_next;
    logic [D:0]   r_len;
    logic [D:0]   r_count;
    logic [D-1:0] r_wr_ptr;
    mach_word_t   r_csum;
    logic         r_done;
    logic         r_err;

    logic w_in_ready;
    logic w_accept;
    logic w_start_take;
    logic w_len_ok;
    logic w_last;
    logic w_we;

    // in_ready depends on registered state only, never on in_valid.
    assign w_in_ready   = (r_state == LOAD) || (r_state == CHECK);
    assign w_accept     = in_valid & w_in_ready;
    assign w_start_take = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
    assign w_len_ok     = (load_len != '0) && (load_len <= DEPTH);
    assign w_last       = ((r_count + 1'b1) == r_len);
    assign w_we         = (r_state == LOAD) && w_accept;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (w_start_take) begin
                    w_next = w_len_ok ? LOAD : ERR;
                end
            end
            LOAD: begin
                if (w_accept && w_last) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (w_accept) begin
                    w_next = (in_data == r_csum) ? DONE : ERR;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_csum   <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_take) begin
                r_len    <= load_len;
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_csum   <= '0;
                r_done   <= 1'b0;
                r_err    <= !w_len_ok;
            end else if (w_we) begin
                // wr_ptr is D bits, so a full 2**D load wraps it back to 0 on entering CHECK.
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + 1'b1;
                r_csum   <= r_csum ^ in_data;
            end else if ((r_state == CHECK) && w_accept) begin
                r_done <= (in_data == r_csum);
                r_err  <= (in_data != r_csum);
            end
        end
    end

    instr_ram #(.D(D)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (prog_ctr),
        .o_rdata (mach_code)
    );

    assign in_ready = w_in_ready;
    assign cpu_hold = (r_state != DONE);
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: directed program loads with hand-computed outcomes.
module tb_instr_loader;
    import instr_pkg::*;

    localparam int unsigned D = 10;

    logic         clk;
    logic         reset;
    logic         start;
    logic [D:0]   load_len;
    logic         in_valid;
    mach_word_t   in_data;
    logic         in_ready;
    logic [D-1:0] prog_ctr;
    mach_word_t   mach_code;
    logic         cpu_hold;
    logic         done;
    logic         err;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;

    typedef struct packed {
        logic done;
        logic err;
        logic hold;
    } exp_t;

    exp_t sb_q[$];

    instr_loader #(.D(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_len  (load_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .prog_ctr  (prog_ctr),
        .mach_code (mach_code),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Accept counter: inputs change just after posedge, so negedge sees what the next edge takes.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && in_valid && in_ready) acc_cnt++;
        end
    end

    // Monitor: every new non-zero {done,err} outcome pops one expected status.
    initial begin
        logic [1:0] prev;
        exp_t e;
        prev = 2'b00;
        forever begin
            @(negedge clk);
            if ({done, err} != prev && {done, err} != 2'b00) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_outcome", {30'd0, done, err}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_done", {31'd0, done}, {31'd0, e.done});
                    chk("sb_err", {31'd0, err}, {31'd0, e.err});
                    chk("sb_cpu_hold", {31'd0, cpu_hold}, {31'd0, e.hold});
                end
            end
            prev = {done, err};
        end
    end

    task automatic pulse_start(input logic [D:0] len);
        start    = 1'b1;
        load_len = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_word(input mach_word_t w);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_flag(string name, bit want_err);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (want_err ? err : done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic rd(string name, input logic [D-1:0] a, input mach_word_t exp);
        prog_ctr = a;
        #1;
        chk(name, {23'd0, mach_code}, {23'd0, exp});
    endtask

    initial begin
        int acc0;
        mach_word_t cs;
        reset    = 1'b1;
        start    = 1'b0;
        load_len = '0;
        in_valid = 1'b0;
        in_data  = '0;
        prog_ctr = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: idle after reset
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t1_cpu_hold", {31'd0, cpu_hold}, 32'd1);
            chk("t1_done", {31'd0, done}, 32'd0);
            chk("t1_err", {31'd0, err}, 32'd0);
            chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;

        // 2: good 3-word load; in_valid raised together with start must not be accepted
        acc0     = acc_cnt;
        start    = 1'b1;
        load_len = 11'd3;
        in_valid = 1'b1;
        in_data  = 9'h0A1;
        @(negedge clk);
        chk("t2_ready_on_start", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        send_word(9'h0A1);
        send_word(9'h1FF);
        send_word(9'h003);
        sb_q.push_back('{done: 1'b1, err: 1'b0, hold: 1'b0});
        send_word(9'h15D);
        in_valid = 1'b0;
        wait_flag("t2_done_wait", 1'b0);
        chk("t2_accepts", acc_cnt - acc0, 32'd4);
        rd("t2_ram0", 10'd0, 9'h0A1);
        rd("t2_ram1", 10'd1, 9'h1FF);
        rd("t2_ram2", 10'd2, 9'h003);
        @(posedge clk);
        #1;

        // bad length 0 taken from DONE
        sb_q.push_back('{done: 1'b0, err: 1'b1, hold: 1'b1});
        pulse_start(11'd0);
        wait_flag("bad_len0_wait", 1'b1);

        // 3: same program, wrong checksum
        pulse_start(11'd3);
        @(negedge clk);
        chk("t3_err_cleared", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        send_word(9'h0A1);
        send_word(9'h1FF);
        send_word(9'h003);
        sb_q.push_back('{done: 1'b0, err: 1'b1, hold: 1'b1});
        send_word(9'h000);
        in_valid = 1'b0;
        wait_flag("t3_err_wait", 1'b1);
        rd("t3_ram0", 10'd0, 9'h0A1);
        rd("t3_ram2", 10'd2, 9'h003);
        @(posedge clk);
        #1;

        // 4: 5-word load with in_valid dropped for a cycle between words
        acc0 = acc_cnt;
        pulse_start(11'd5);
        send_word(9'h101); in_valid = 1'b0; @(posedge clk); #1;
        send_word(9'h0F0); in_valid = 1'b0; @(posedge clk); #1;
        send_word(9'h00F); in_valid = 1'b0; @(posedge clk); #1;
        send_word(9'h1AA); in_valid = 1'b0; @(posedge clk); #1;
        send_word(9'h055); in_valid = 1'b0; @(posedge clk); #1;
        sb_q.push_back('{done: 1'b1, err: 1'b0, hold: 1'b0});
        send_word(9'h001);
        in_valid = 1'b0;
        wait_flag("t4_done_wait", 1'b0);
        chk("t4_accepts", acc_cnt - acc0, 32'd6);
        rd("t4_ram0", 10'd0, 9'h101);
        rd("t4_ram1", 10'd1, 9'h0F0);
        rd("t4_ram3", 10'd3, 9'h1AA);
        rd("t4_ram4", 10'd4, 9'h055);
        @(posedge clk);
        #1;

        // bad length 2**D+1 taken from DONE
        sb_q.push_back('{done: 1'b0, err: 1'b1, hold: 1'b1});
        pulse_start(11'd1025);
        wait_flag("bad_len1025_wait", 1'b1);

        // 5: full-depth load, data = address[8:0]; each 9-bit value occurs twice so csum is 0
        acc0 = acc_cnt;
        pulse_start(11'd1024);
        cs = '0;
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] iv;
            iv = i;
            send_word(iv[8:0]);
            cs = cs ^ iv[8:0];
        end
        chk("t5_model_csum", {23'd0, cs}, 32'h000);
        sb_q.push_back('{done: 1'b1, err: 1'b0, hold: 1'b0});
        send_word(9'h000);
        in_valid = 1'b0;
        wait_flag("t5_done_wait", 1'b0);
        chk("t5_accepts", acc_cnt - acc0, 32'd1025);
        rd("t5_ram0", 10'd0, 9'h000);
        rd("t5_ram1", 10'd1, 9'h001);
        rd("t5_ram511", 10'd511, 9'h1FF);
        rd("t5_ram512", 10'd512, 9'h000);
        rd("t5_ram1023", 10'd1023, 9'h1FF);
        @(posedge clk);
        #1;

        // 6: reset mid-load, then a 1-word reload
        pulse_start(11'd4);
        send_word(9'h111);
        send_word(9'h122);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_hold_after_reset", {31'd0, cpu_hold}, 32'd1);
        chk("t6_ready_after_reset", {31'd0, in_ready}, 32'd0);
        chk("t6_done_after_reset", {31'd0, done}, 32'd0);
        chk("t6_err_after_reset", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        pulse_start(11'd1);
        send_word(9'h055);
        sb_q.push_back('{done: 1'b1, err: 1'b0, hold: 1'b0});
        send_word(9'h055);
        in_valid = 1'b0;
        wait_flag("t6_done_wait", 1'b0);
        rd("t6_ram0", 10'd0, 9'h055);
        rd("t6_ram1", 10'd1, 9'h122);
        rd("t6_ram2", 10'd2, 9'h002);

        repeat (3) @(posedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
